// File: rtl/moving_average_window.sv
// moving_average_window
//   Power-of-two moving average over the last WIN = 2^LOG2_WIN price samples.
//   Samples land in a circular buffer. A running sum is kept and updated
//   incrementally: the new sample is added and the evicted one is subtracted.
//   Each accepted sample produces one averaged result.
//   Optional feature: define MA_ROUND_EN to round half up instead of truncating.
//
// Handshake (both sides use plain valid/ready):
//   - A transfer happens on a rising edge where valid and ready are both 1.
//   - in_ready is 1 only in IDLE.
//   - out_valid stays 1 in HOLD, and out_avg is held stable, until the edge
//     where out_ready is 1.
//   - A producer must not make valid depend on ready.
module moving_average_window #(
  parameter int DATA_W   = 32,
  parameter int LOG2_WIN = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_price,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_avg,
  output logic              out_full,
  output logic [1:0]        fsm_state
);

  localparam int WIN   = 1 << LOG2_WIN;
  localparam int SUM_W = DATA_W + LOG2_WIN;
  localparam int PTR_W = (LOG2_WIN > 0) ? LOG2_WIN : 1;
  localparam int CNT_W = LOG2_WIN + 1;
  localparam int RSH   = (LOG2_WIN > 0) ? LOG2_WIN - 1 : 0;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(WIN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(WIN);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIN - 1);
  localparam logic [SUM_W-1:0] ROUND_ADD = (LOG2_WIN > 0) ? (SUM_W'(1) << RSH) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] buffer [WIN];
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] oldest;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_next;
  logic [SUM_W-1:0]  sum_round;
  logic [DATA_W-1:0] avg_next;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  assign in_ready  = (state == IDLE);
  assign fsm_state = state;

  // State register; reset takes priority over everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; clear forces IDLE from any state and wins over in_valid.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_next = ACCUM;
        ACCUM:   state_next = HOLD;
        HOLD:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Sum update and average.
  // Before the window has filled, the evicted slot is treated as zero.
  // The intermediate sum + new may wrap, but the final result always fits,
  // so modular arithmetic stays exact.
  always_comb begin
    oldest   = out_full ? buffer[wr_ptr] : '0;
    sum_next = sum + SUM_W'(sample) - SUM_W'(oldest);
`ifdef MA_ROUND_EN
    sum_round = sum_next + ROUND_ADD;
`else
    sum_round = sum_next;
`endif
    avg_next = DATA_W'(sum_round >> LOG2_WIN);
  end

  // Datapath registers: capture, accumulate, hold result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample    <= '0;
      sum       <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      out_avg   <= '0;
      out_valid <= 1'b0;
      out_full  <= 1'b0;
    end else if (clear) begin
      sum       <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      out_full  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) sample <= in_price;
        end
        ACCUM: begin
          sum       <= sum_next;
          wr_ptr    <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
          if (count != CNT_FULL) count <= count + CNT_W'(1);
          if (count == CNT_LAST) out_full <= 1'b1;
          out_avg   <= avg_next;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Sample storage. It needs no reset because out_full gates every read.
  always_ff @(posedge clk) begin
    if (rst_n && !clear && state == ACCUM) buffer[wr_ptr] <= sample;
  end

endmodule

// File: tb/tb_moving_average_window.sv
// tb_moving_average_window
//   Directed plus randomized stimulus for moving_average_window.
//   The configuration is DATA_W=32 and LOG2_WIN=2.
//   The reference keeps the last WIN samples in a queue and averages them
//   with plain arithmetic.
//   It honours MA_ROUND_EN in the same way as the design.
module tb_moving_average_window;

  localparam int DATA_W   = 32;
  localparam int LOG2_WIN = 2;
  localparam int WIN      = 1 << LOG2_WIN;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] in_price;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_avg;
  logic              out_full;
  logic [1:0]        fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DATA_W-1:0] exp_q[$];
  int                seen_since_clear = 0;

  moving_average_window #(.DATA_W(DATA_W), .LOG2_WIN(LOG2_WIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_price  (in_price),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_avg   (out_avg),
    .out_full  (out_full),
    .fsm_state (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    seen_since_clear = 0;
  endtask

  task automatic model_push(input logic [DATA_W-1:0] p);
    exp_q.push_back(p);
    if (exp_q.size() > WIN) void'(exp_q.pop_front());
    seen_since_clear++;
  endtask

  function automatic logic [63:0] model_avg();
    logic [63:0] s = 64'd0;
    foreach (exp_q[i]) s += 64'(exp_q[i]);
`ifdef MA_ROUND_EN
    s += 64'(WIN / 2);
`endif
    return s / 64'(WIN);
  endfunction

  function automatic logic [63:0] model_full();
    return (seen_since_clear >= WIN) ? 64'd1 : 64'd0;
  endfunction

  // Sends one sample and checks the result.
  // hold:    number of cycles to keep out_ready low in HOLD, while offering
  //          a sample that must be ignored.
  // clr_hold: end the HOLD with clear instead of out_ready.
  task automatic send(input logic [DATA_W-1:0] p, input int hold, input bit clr_hold);
    int waited;
    logic [DATA_W-1:0] held;
    waited = 0;
    while (!in_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_send", 64'(in_ready), 64'd1);
    in_price = p;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_price = $urandom;
    model_push(p);
    waited = 0;
    while (!out_valid && waited < 6) begin
      @(negedge clk);
      waited++;
    end
    check("out_valid_rise", 64'(out_valid), 64'd1);
    check("out_avg", 64'(out_avg), model_avg());
    check("out_full", 64'(out_full), model_full());
    held = out_avg;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_price = $urandom;
      @(negedge clk);
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_out_avg_stable", 64'(out_avg), 64'(held));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    if (clr_hold) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_clear();
      check("clear_out_valid", 64'(out_valid), 64'd0);
      check("clear_out_full", 64'(out_full), 64'd0);
      check("clear_in_ready", 64'(in_ready), 64'd1);
    end else begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_drop", 64'(out_valid), 64'd0);
    end
  endtask

  // Directed sequence followed by a random phase
  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_price  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_avg", 64'(out_avg), 64'd0);
    check("rst_out_full", 64'(out_full), 64'd0);

    // Warm-up and eviction: 10,20,30,40,50,60
    send(32'd10, 0, 1'b0);
`ifndef MA_ROUND_EN
    check("first_avg_trunc", 64'(out_avg), 64'd2);
`else
    check("first_avg_round", 64'(out_avg), 64'd3);
`endif
    send(32'd20, 0, 1'b0);
    send(32'd30, 0, 1'b0);
    check("full_before_4th", 64'(out_full), 64'd0);
    send(32'd40, 0, 1'b0);
    check("full_after_4th", 64'(out_full), 64'd1);
    send(32'd50, 0, 1'b0);
`ifndef MA_ROUND_EN
    check("evict_avg_50", 64'(out_avg), 64'd35);
`endif
    send(32'd60, 0, 1'b0);
`ifndef MA_ROUND_EN
    check("evict_avg_60", 64'(out_avg), 64'd45);
`endif

    // Back-pressure: out_ready low for 5 cycles in HOLD
    send(32'd70, 5, 1'b0);
    send(32'd80, 0, 1'b0);

    // Clear in HOLD after 3 samples, then sample 8
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    send(32'd5, 0, 1'b0);
    send(32'd6, 0, 1'b0);
    send(32'd7, 0, 1'b1);
    send(32'd8, 0, 1'b0);
    check("after_clear_avg8", 64'(out_avg), 64'd2);

    // clear together with in_valid in IDLE drops the sample
    in_valid = 1'b1;
    in_price = 32'd1000;
    clear    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b0;
    model_clear();
    check("clr_win_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("clr_win_out_valid", 64'(out_valid), 64'd0);
    send(32'd400, 0, 1'b0);

    // Saturated samples: no sum overflow
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    for (int i = 0; i < WIN; i++) send(32'hFFFF_FFFF, 0, 1'b0);
    check("max_avg", 64'(out_avg), 64'hFFFF_FFFF);

    // Random phase
    for (int i = 0; i < 40; i++) begin
      send($urandom, $urandom_range(0, 2), 1'b0);
    end

    // Reset while in ACCUM discards the pending result
    in_valid = 1'b1;
    in_price = 32'd1234;
    @(negedge clk);
    in_valid = 1'b0;
    check("accum_state", 64'(fsm_state), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    check("rst_accum_in_ready", 64'(in_ready), 64'd1);
    check("rst_accum_out_valid", 64'(out_valid), 64'd0);
    check("rst_accum_out_avg", 64'(out_avg), 64'd0);
    check("rst_accum_out_full", 64'(out_full), 64'd0);
    @(negedge clk);
    check("rst_accum_no_result", 64'(out_valid), 64'd0);
    send(32'd100, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
